uart_pkt_parser: RTL and testbench

//  Sits directly downstream of the UART receiver and consumes its byte/done strobes.

---
 rtl/uart_pkt_parser.sv | 193 +++++++++++++++++++
 tb/tb_uart_pkt_parser.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_parser.sv
// rtl/uart_pkt_parser.sv - frames UART bytes into SYNC/LEN/payload[/CHK] packets and holds the payload for the command layer
// Optional feature macro: UART_PKT_CHKSUM_EN (trailing CHK byte, sCHK state, checksum accumulator, error code 11).
module uart_pkt_parser #(
    parameter int          CLK_FREQ     = 125_000_000,
    parameter int          MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 125_000,
    localparam int         AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic [7:0]    iRxByte,
    input  logic          iRxDone,
    input  logic [AW-1:0] iRdAddr,
    output logic [7:0]    oRdData,
    output logic          oPktValid,
    output logic [7:0]    oPktLen,
    input  logic          iPktAck,
    output logic          oErr,
    output logic [1:0]    oErrCode,
    output logic          oOverrun
);

    // A non-positive TIMEOUT_CLKS falls back to a 1 ms window derived from the clock frequency.
    localparam int              TIMEOUT_LIMIT = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : CLK_FREQ / 1000 - 1;
    localparam int              GW            = (TIMEOUT_LIMIT > 0) ? $clog2(TIMEOUT_LIMIT + 1) : 1;
    localparam logic [GW-1:0]   GAP_LAST      = GW'(TIMEOUT_LIMIT);
    localparam logic [7:0]      MAX_LEN_B     = 8'(MAX_LEN);
    localparam int              DEPTH         = 2 ** AW;

    typedef enum logic [2:0] {
        sIDLE,
        sLEN,
        sPAYLOAD,
`ifdef UART_PKT_CHKSUM_EN
        sCHK,
`endif
        sHOLD
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            wr_en;
    logic            in_frame;
    logic [7:0]      pay_mem [0:DEPTH-1];
`ifdef UART_PKT_CHKSUM_EN
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      chk_sum;
`endif

    // Next-state, framing, error detection and gap timeout.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        overrun_d  = 1'b0;
        wr_en      = 1'b0;
        in_frame   = 1'b0;
        rd_data_d  = pay_mem[iRdAddr];
`ifdef UART_PKT_CHKSUM_EN
        acc_d      = acc_q;
        chk_sum    = acc_q + iRxByte;
`endif
        case (state_q)
            sIDLE: begin
                gap_d = '0;
                if (iRxDone && iRxByte == SYNC_BYTE) begin
                    state_d = sLEN;
                end
            end
            sLEN: begin
                in_frame = 1'b1;
                if (iRxDone) begin
                    gap_d = '0;
                    if (iRxByte == 8'd0 || iRxByte > MAX_LEN_B) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = sIDLE;
                    end else begin
                        len_d   = iRxByte;
                        idx_d   = 8'd0;
`ifdef UART_PKT_CHKSUM_EN
                        acc_d   = iRxByte;
`endif
                        state_d = sPAYLOAD;
                    end
                end
            end
            sPAYLOAD: begin
                in_frame = 1'b1;
                if (iRxDone) begin
                    gap_d = '0;
                    wr_en = 1'b1;
                    idx_d = idx_q + 8'd1;
`ifdef UART_PKT_CHKSUM_EN
                    acc_d = chk_sum;
                    if (idx_q == len_q - 8'd1) state_d = sCHK;
`else
                    if (idx_q == len_q - 8'd1) state_d = sHOLD;
`endif
                end
            end
`ifdef UART_PKT_CHKSUM_EN
            sCHK: begin
                in_frame = 1'b1;
                if (iRxDone) begin
                    gap_d = '0;
                    if (chk_sum == 8'd0) begin
                        state_d = sHOLD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b11;
                        state_d    = sIDLE;
                    end
                end
            end
`endif
            sHOLD: begin
                gap_d = '0;
                // A byte arriving while the buffer is owned by the consumer is dropped,
                // even when the ack lands in the same cycle.
                if (iRxDone) overrun_d = 1'b1;
                if (iPktAck) state_d = sIDLE;
            end
            default: begin
                state_d = sIDLE;
                gap_d   = '0;
            end
        endcase

        if (in_frame && !iRxDone) begin
            if (gap_q == GAP_LAST) begin
                err_d      = 1'b1;
                err_code_d = 2'b10;
                state_d    = sIDLE;
                gap_d      = '0;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end
    end

    // State and output registers; asynchronous reset clears everything except the buffer.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= sIDLE;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            gap_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            overrun_q  <= 1'b0;
            rd_data_q  <= 8'd0;
`ifdef UART_PKT_CHKSUM_EN
            acc_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            overrun_q  <= overrun_d;
            rd_data_q  <= rd_data_d;
`ifdef UART_PKT_CHKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    // Payload buffer write port; contents are not reset.
    always_ff @(posedge iClk) begin
        if (wr_en) pay_mem[idx_q[AW-1:0]] <= iRxByte;
    end

    assign oRdData   = rd_data_q;
    assign oPktValid = (state_q == sHOLD);
    assign oPktLen   = oPktValid ? len_q : 8'd0;
    assign oErr      = err_q;
    assign oErrCode  = err_code_q;
    assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// tb/tb_uart_pkt_parser.sv - randomized self-checking bench for uart_pkt_parser against a frame-level queue model
module tb_uart_pkt_parser;

    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 200;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         AW      = 4;
`ifdef UART_PKT_CHKSUM_EN
    localparam int         CHK_EN  = 1;
`else
    localparam int         CHK_EN  = 0;
`endif

    logic          iClk = 1'b0;
    logic          iRst;
    logic [7:0]    iRxByte;
    logic          iRxDone;
    logic [AW-1:0] iRdAddr;
    logic [7:0]    oRdData;
    logic          oPktValid;
    logic [7:0]    oPktLen;
    logic          iPktAck;
    logic          oErr;
    logic [1:0]    oErrCode;
    logic          oOverrun;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the frame in progress, the held packet, and the last error code.
    logic [7:0] frame [$];
    logic [7:0] m_pay [$];
    logic       m_hold = 1'b0;
    logic [7:0] m_len  = 8'd0;
    logic [1:0] m_code = 2'b00;

    uart_pkt_parser #(
        .CLK_FREQ    (125_000_000),
        .MAX_LEN     (MAX_LEN),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iRxByte  (iRxByte),
        .iRxDone  (iRxDone),
        .iRdAddr  (iRdAddr),
        .oRdData  (oRdData),
        .oPktValid(oPktValid),
        .oPktLen  (oPktLen),
        .iPktAck  (iPktAck),
        .oErr     (oErr),
        .oErrCode (oErrCode),
        .oOverrun (oOverrun)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic model_reset();
        frame.delete();
        m_pay.delete();
        m_hold = 1'b0;
        m_len  = 8'd0;
        m_code = 2'b00;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic e, output logic o);
        int s;
        e = 1'b0;
        o = 1'b0;
        if (m_hold) begin
            o = 1'b1;
        end else if (frame.size() == 0) begin
            if (b == SYNC) frame.push_back(b);
        end else begin
            frame.push_back(b);
            if (frame.size() == 2 && (b == 8'd0 || int'(b) > MAX_LEN)) begin
                e = 1'b1;
                m_code = 2'b01;
                frame.delete();
            end else if (frame.size() == 2 + int'(frame[1]) + CHK_EN) begin
                s = 0;
                for (int i = 1; i < frame.size(); i++) s += int'(frame[i]);
                if (CHK_EN == 1 && (s % 256) != 0) begin
                    e = 1'b1;
                    m_code = 2'b11;
                end else begin
                    m_hold = 1'b1;
                    m_len  = frame[1];
                    m_pay.delete();
                    for (int i = 0; i < int'(frame[1]); i++) m_pay.push_back(frame[2 + i]);
                end
                frame.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        logic e, o, hb;
        iRxByte = b;
        iRxDone = 1'b1;
        iPktAck = ack;
        step();
        iRxDone = 1'b0;
        iPktAck = 1'b0;
        hb = m_hold;
        model_byte(b, e, o);
        if (ack && hb) m_hold = 1'b0;
        check("err", oErr, e);
        check("err_code", oErrCode, m_code);
        check("overrun", oOverrun, o);
        check("pkt_valid", oPktValid, m_hold);
        check("pkt_len", oPktLen, m_hold ? m_len : 8'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check("idle_err", oErr, 0);
            check("idle_ovr", oOverrun, 0);
        end
    endtask

    // Short random gaps go before each byte so the frame's last byte is followed directly by the caller.
    task automatic send_seq(input logic [7:0] q [$]);
        for (int i = 0; i < q.size(); i++) begin
            idle($urandom_range(0, 2));
            send_byte(q[i], (!m_hold && $urandom_range(0, 7) == 0));
        end
    endtask

    task automatic timeout_wait();
        int pulses;
        int at;
        logic exp;
        pulses = 0;
        at = -1;
        exp = (frame.size() != 0);
        for (int k = 1; k <= TMO + 5; k++) begin
            step();
            if (oErr === 1'b1) begin
                pulses++;
                at = k;
            end
        end
        check("tmo_pulses", pulses, exp);
        if (exp) begin
            check("tmo_window", (at >= TMO - 2 && at <= TMO + 1), 1);
            m_code = 2'b10;
            frame.delete();
        end
        check("tmo_code", oErrCode, m_code);
    endtask

    task automatic read_payload();
        for (int i = 0; i < int'(m_len); i++) begin
            iRdAddr = AW'(i);
            step();
            check("rd_data", oRdData, m_pay[i]);
        end
    endtask

    task automatic handle_hold();
        if (m_hold) begin
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom), 1'b0);
            read_payload();
            if ($urandom_range(0, 1) == 0) begin
                send_byte(8'($urandom), 1'b1);
            end else begin
                iPktAck = 1'b1;
                step();
                iPktAck = 1'b0;
                m_hold = 1'b0;
                check("ack_valid", oPktValid, 0);
                check("ack_len", oPktLen, 0);
                check("ack_ovr", oOverrun, 0);
            end
        end
    endtask

    function automatic void build_good(ref logic [7:0] q [$], input int len, input int chk_delta);
        int s;
        logic [7:0] b;
        q.delete();
        q.push_back(SYNC);
        q.push_back(8'(len));
        s = len;
        for (int i = 0; i < len; i++) begin
            b = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
            q.push_back(b);
            s += int'(b);
        end
        if (CHK_EN == 1) q.push_back(8'(0 - s + chk_delta));
    endfunction

    task automatic rand_frame();
        logic [7:0] q [$];
        logic [7:0] b;
        int kind;
        int len;
        kind = $urandom_range(0, 5);
        case (kind)
            0, 1: begin
                build_good(q, $urandom_range(1, MAX_LEN), 0);
                send_seq(q);
            end
            2: begin
                q.push_back(SYNC);
                q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
                send_seq(q);
            end
            3: begin
                build_good(q, $urandom_range(1, MAX_LEN), $urandom_range(1, 255));
                send_seq(q);
            end
            4: begin
                for (int i = 0; i < $urandom_range(1, 3); i++) begin
                    do b = 8'($urandom); while (b == SYNC);
                    q.push_back(b);
                end
                send_seq(q);
            end
            default: begin
                len = $urandom_range(1, MAX_LEN);
                q.push_back(SYNC);
                q.push_back(8'(len));
                for (int i = 0; i < $urandom_range(0, len - 1); i++) q.push_back(8'($urandom));
                send_seq(q);
                timeout_wait();
            end
        endcase
        handle_hold();
        idle($urandom_range(0, 3));
    endtask

    initial begin
        logic [7:0] q [$];
        iRst    = 1'b1;
        iRxByte = 8'd0;
        iRxDone = 1'b0;
        iRdAddr = '0;
        iPktAck = 1'b0;
        repeat (3) step();
        check("rst_err", oErr, 0);
        check("rst_code", oErrCode, 0);
        check("rst_ovr", oOverrun, 0);
        check("rst_valid", oPktValid, 0);
        check("rst_len", oPktLen, 0);
        check("rst_rd", oRdData, 0);
        iRst = 1'b0;
        step();

        // Three-byte packet, read back, then overrun and an ack coinciding with a byte.
        q = '{SYNC, 8'h03, 8'h11, 8'h22, 8'h33};
        if (CHK_EN == 1) q.push_back(8'h97);
        send_seq(q);
        check("pkt3_valid", oPktValid, 1);
        check("pkt3_len", oPktLen, 3);
        read_payload();
        send_byte(8'h55, 1'b0);
        check("ovr_pulse", oOverrun, 1);
        check("ovr_len_kept", oPktLen, 3);
        read_payload();
        send_byte(8'h66, 1'b1);
        check("ack_ovr_pulse", oOverrun, 1);
        check("ack_ovr_valid", oPktValid, 0);
        idle(2);

`ifdef UART_PKT_CHKSUM_EN
        q = '{SYNC, 8'h02, 8'h10, 8'h20, 8'h00};
        send_seq(q);
        check("chk_err_code", oErrCode, 2'b11);
        check("chk_no_valid", oPktValid, 0);
`endif
        handle_hold();
        idle(2);

        q = '{SYNC, 8'h00};
        send_seq(q);
        check("len0_code", oErrCode, 2'b01);
        q = '{SYNC, 8'h11};
        send_seq(q);
        check("len17_code", oErrCode, 2'b01);
        idle(2);

        q = '{SYNC, 8'h04, 8'h01};
        send_seq(q);
        timeout_wait();
        check("tmo_code_const", oErrCode, 2'b10);
        q = '{8'h00, 8'hFF, 8'h5A, SYNC, 8'h01, 8'h7E};
        if (CHK_EN == 1) q.push_back(8'h81);
        send_seq(q);
        check("garbage_valid", oPktValid, 1);
        check("garbage_len", oPktLen, 1);
        iRdAddr = '0;
        step();
        check("garbage_pay", oRdData, 8'h7E);
        handle_hold();
        idle(2);

        for (int n = 0; n < 60; n++) rand_frame();

        // Asynchronous reset in the middle of a payload.
        iRdAddr = '0;
        q = '{SYNC, 8'h05, 8'h44, 8'h55};
        send_seq(q);
        #2;
        iRst = 1'b1;
        #1;
        check("mid_rst_rd", oRdData, 0);
        check("mid_rst_valid", oPktValid, 0);
        check("mid_rst_len", oPktLen, 0);
        check("mid_rst_err", oErr, 0);
        check("mid_rst_code", oErrCode, 0);
        check("mid_rst_ovr", oOverrun, 0);
        step();
        iRst = 1'b0;
        model_reset();
        step();
        q = '{8'h33, 8'h44};
        send_seq(q);
        build_good(q, 2, 0);
        send_seq(q);
        check("post_rst_valid", oPktValid, 1);
        handle_hold();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
